ram_access_unit: RTL and testbench

- Downstream stage of the RAM controller.
- Consumes the registered address, write data and write strobe the controller produces, plus a read request from the execute stage.
- Sequences each access onto a synchronous single-port data RAM with a configurable number of wait states.
- Returns read data with a valid pulse, and stalls the core through busy when its one-entry holding buffer is occupied.

---
 rtl/ram_access_unit.sv | 173 +++++++++++++++++
 tb/tb_ram_access_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_unit.sv
// Sequences captured write/read requests onto a synchronous single-port data RAM
// with WAIT extra strobe cycles, a one-entry holding buffer and a sticky error flag.
module ram_access_unit #(
    parameter int unsigned WAIT      = 1,
    parameter int unsigned MEM_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] RAMaddr,
    input  logic [15:0] toRAM,
    input  logic        w,
    input  logic        rd,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [15:0] rdata,
    output logic        rvalid,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 3;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_NEXT   = 2'd2
    } state_t;

    state_t        state_q;
    logic          req_v_q;
    req_t          req_q;
    logic          buf_v_q;
    req_t          buf_q;
    logic [CW-1:0] cnt_q;
    logic          cur_we_q;
    logic          cur_ok_q;
    logic          rd_pend_q;
    logic [DW-1:0] rd_stage_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_we_q;
    logic          mem_re_q;
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;
    logic          err_q;

    logic launch_buf;
    logic launch_req;
    logic launch;
    logic store;
    logic drop;
    logic in_range;
    req_t launch_sel;

    // Launch selection: buffered request has priority; a captured request that
    // cannot launch is buffered if the buffer is empty, otherwise dropped.
    always_comb begin
        launch_buf = 1'b0;
        launch_req = 1'b0;
        store      = 1'b0;
        drop       = 1'b0;
        if (state_q != S_ACCESS) begin
            launch_buf = buf_v_q;
            launch_req = (state_q == S_IDLE) && req_v_q && !buf_v_q;
        end
        if (req_v_q && !launch_req) begin
            store = !buf_v_q;
            drop  = buf_v_q;
        end
        launch     = launch_buf | launch_req;
        launch_sel = launch_buf ? buf_q : req_q;
        in_range   = 32'(launch_sel.addr) < MEM_WORDS;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_v_q     <= 1'b0;
            req_q       <= '0;
            buf_v_q     <= 1'b0;
            buf_q       <= '0;
            cnt_q       <= '0;
            cur_we_q    <= 1'b0;
            cur_ok_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_stage_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Write wins when both request lines are high.
            req_v_q <= w | rd;
            req_q   <= {w, RAMaddr, toRAM};

            rvalid_q  <= rd_pend_q;
            rd_pend_q <= 1'b0;
            if (rd_pend_q) begin
                rdata_q <= rd_stage_q;
            end

            if (store) begin
                buf_q   <= req_q;
                buf_v_q <= 1'b1;
            end else if (launch_buf) begin
                buf_v_q <= 1'b0;
            end

            if (drop) begin
                err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE, S_NEXT: begin
                    if (launch) begin
                        mem_addr_q  <= launch_sel.addr;
                        mem_wdata_q <= launch_sel.data;
                        mem_we_q    <= launch_sel.we && in_range;
                        mem_re_q    <= !launch_sel.we && in_range;
                        cur_we_q    <= launch_sel.we;
                        cur_ok_q    <= in_range;
                        cnt_q       <= CW'(WAIT);
                        if (!in_range) begin
                            err_q <= 1'b1;
                        end
                        state_q <= S_ACCESS;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        mem_we_q <= 1'b0;
                        mem_re_q <= 1'b0;
                        // Out-of-range reads still return, with zero data.
                        if (!cur_we_q) begin
                            rd_pend_q  <= 1'b1;
                            rd_stage_q <= cur_ok_q ? mem_rdata : '0;
                        end
                        state_q <= S_NEXT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign busy      = buf_v_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ram_access_unit.sv
// Directed self-checking bench for ram_access_unit with a synchronous RAM model.
module tb_ram_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] RAMaddr = '0;
    logic [15:0] toRAM = '0;
    logic        w = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] rdata;
    logic        rvalid;
    logic        busy;
    logic        err;

    logic [15:0] ram [0:16383] = '{default: 16'h0000};

    int n_checks = 0;
    int n_fails  = 0;
    int we_cyc   = 0;
    int re_cyc   = 0;
    int rv_cnt   = 0;
    int both_cnt = 0;
    int we0, re0, rv0;

    ram_access_unit #(.WAIT(1), .MEM_WORDS(16384)) dut (
        .clk       (clk),
        .rst       (rst),
        .RAMaddr   (RAMaddr),
        .toRAM     (toRAM),
        .w         (w),
        .rd        (rd),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data registered on a strobed edge.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[13:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr[13:0]];
    end

    always @(negedge clk) begin
        if (mem_we) we_cyc <= we_cyc + 1;
        if (mem_re) re_cyc <= re_cyc + 1;
        if (rvalid) rv_cnt <= rv_cnt + 1;
        if (mem_we && mem_re) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        we0 = we_cyc;
        re0 = re_cyc;
        rv0 = rv_cnt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic issue(input logic wi, input logic ri, input logic [15:0] a, input logic [15:0] d);
        w = wi;
        rd = ri;
        RAMaddr = a;
        toRAM = d;
        tick();
        w = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_mem_we", 16'(mem_we), 16'h0);
        chk("rst_mem_re", 16'(mem_re), 16'h0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_rvalid", 16'(rvalid), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        rst = 1'b0;
        tick();

        // Single write.
        snap();
        issue(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        chk("wr_not_yet", 16'(mem_we), 16'h0);
        tick();
        chk("wr_we_c1", 16'(mem_we), 16'h1);
        chk("wr_addr", mem_addr, 16'h0010);
        chk("wr_wdata", mem_wdata, 16'hBEEF);
        chk("wr_busy", 16'(busy), 16'h0);
        tick();
        chk("wr_we_c2", 16'(mem_we), 16'h1);
        tick();
        chk("wr_we_off", 16'(mem_we), 16'h0);
        tick();
        tick();
        chk("wr_we_cycles", 16'(we_cyc - we0), 16'd2);
        chk("wr_ram", ram[16'h0010], 16'hBEEF);

        // Single read, rvalid WAIT+3 cycles after the rd edge.
        snap();
        issue(1'b0, 1'b1, 16'h0010, 16'h0000);
        tick();
        chk("rd_re_c1", 16'(mem_re), 16'h1);
        chk("rd_addr", mem_addr, 16'h0010);
        tick();
        chk("rd_re_c2", 16'(mem_re), 16'h1);
        tick();
        chk("rd_re_off", 16'(mem_re), 16'h0);
        chk("rd_rvalid_early", 16'(rvalid), 16'h0);
        tick();
        chk("rd_rvalid", 16'(rvalid), 16'h1);
        chk("rd_rdata", rdata, 16'hBEEF);
        tick();
        chk("rd_rvalid_pulse", 16'(rvalid), 16'h0);
        chk("rd_rdata_hold", rdata, 16'hBEEF);
        chk("rd_re_cycles", 16'(re_cyc - re0), 16'd2);

        // Write and read together: only the write happens.
        snap();
        issue(1'b1, 1'b1, 16'h0020, 16'h1234);
        repeat (7) tick();
        chk("wr_rd_we_cycles", 16'(we_cyc - we0), 16'd2);
        chk("wr_rd_re_cycles", 16'(re_cyc - re0), 16'd0);
        chk("wr_rd_no_rvalid", 16'(rv_cnt - rv0), 16'd0);
        chk("wr_rd_ram", ram[16'h0020], 16'h1234);

        // Out-of-range read, then a write at the last valid word.
        chk("oor_err_before", 16'(err), 16'h0);
        snap();
        issue(1'b0, 1'b1, 16'h4000, 16'h0000);
        tick();
        chk("oor_no_re", 16'(mem_re), 16'h0);
        chk("oor_err", 16'(err), 16'h1);
        tick();
        tick();
        tick();
        chk("oor_rvalid", 16'(rvalid), 16'h1);
        chk("oor_rdata", rdata, 16'h0000);
        tick();
        tick();
        chk("oor_re_cycles", 16'(re_cyc - re0), 16'd0);
        snap();
        issue(1'b1, 1'b0, 16'h3FFF, 16'hCAFE);
        tick();
        chk("top_we", 16'(mem_we), 16'h1);
        chk("top_addr", mem_addr, 16'h3FFF);
        repeat (5) tick();
        chk("top_we_cycles", 16'(we_cyc - we0), 16'd2);
        chk("top_ram", ram[16'h3FFF], 16'hCAFE);
        chk("top_err_sticky", 16'(err), 16'h1);

        // Three back-to-back writes: execute, buffer, drop.
        do_reset();
        chk("b2b_err_cleared", 16'(err), 16'h0);
        snap();
        issue(1'b1, 1'b0, 16'h0100, 16'h1111);
        issue(1'b1, 1'b0, 16'h0101, 16'h2222);
        issue(1'b1, 1'b0, 16'h0102, 16'h3333);
        chk("b2b_busy", 16'(busy), 16'h1);
        chk("b2b_we_first", 16'(mem_we), 16'h1);
        chk("b2b_first_addr", mem_addr, 16'h0100);
        tick();
        chk("b2b_err", 16'(err), 16'h1);
        chk("b2b_gap", 16'(mem_we), 16'h0);
        tick();
        chk("b2b_second_we", 16'(mem_we), 16'h1);
        chk("b2b_second_addr", mem_addr, 16'h0101);
        chk("b2b_busy_clear", 16'(busy), 16'h0);
        repeat (5) tick();
        chk("b2b_we_cycles", 16'(we_cyc - we0), 16'd4);
        chk("b2b_ram_second", ram[16'h0101], 16'h2222);
        chk("b2b_ram_dropped", ram[16'h0102], 16'h0000);

        // Reset during the second strobe cycle of a read with a write buffered.
        do_reset();
        snap();
        issue(1'b0, 1'b1, 16'h0010, 16'h0000);
        issue(1'b1, 1'b0, 16'h0200, 16'h5555);
        tick();
        chk("mid_re_c2", 16'(mem_re), 16'h1);
        chk("mid_busy", 16'(busy), 16'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_re", 16'(mem_re), 16'h0);
        chk("mid_rst_busy", 16'(busy), 16'h0);
        chk("mid_rst_addr", mem_addr, 16'h0000);
        chk("mid_rst_rvalid", 16'(rvalid), 16'h0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("mid_no_rvalid", 16'(rv_cnt - rv0), 16'd0);
        chk("mid_no_we", 16'(we_cyc - we0), 16'd0);
        chk("mid_ram_untouched", ram[16'h0200], 16'h0000);
        chk("one_hot_strobes", 16'(both_cnt), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
